// File: rtl/cpu_seq.sv
// cpu_seq: datapath and sequencer for the 4-phase CPU.
//
// The external phase state machine steps through fetch (0001), decode (0010),
// execute (0100) and writeback (1000). This block holds PC, IR, the
// accumulator and the Z/C flags, drives the instruction and data memory
// ports, and raises stop in writeback when the phase machine should idle.
//
// Ports:
//   CLK         in   rising-edge clock
//   RSTN        in   asynchronous active-low reset
//   phase       in   one-hot phase vector (0000 = idle, non-one-hot ignored)
//   imem_addr   out  instruction address, always equal to pc
//   imem_data   in   instruction word (combinational read)
//   dmem_addr   out  data address, IR[DMEM_AW-1:0]
//   dmem_rdata  in   data read value (combinational read)
//   dmem_wdata  out  write data, always equal to acc
//   dmem_we     out  one-cycle write strobe during ST writeback
//   stop        out  halt request, high during HALT writeback
//   pc, acc     out  program counter / accumulator (debug)
//   zf, cf      out  zero flag / carry-borrow flag
//   illegal     out  sticky illegal-opcode flag
//
// Optional feature: define CPU_SEQ_ILLEGAL_TRAP_EN to make opcodes 9..E stop
// the machine and set the sticky illegal flag. Without it those opcodes act
// as NOP and illegal is tied to 0.
//
// Handshake: there is no valid/ready pair; the phase vector is the only
// sequencing input, and each one-hot phase value advances the matching
// pipeline step by exactly one clock edge.

module cpu_seq #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter int         DMEM_AW  = 8
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic [3:0]         phase,
  output logic [7:0]         imem_addr,
  input  logic [15:0]        imem_data,
  output logic [DMEM_AW-1:0] dmem_addr,
  input  logic [7:0]         dmem_rdata,
  output logic [7:0]         dmem_wdata,
  output logic               dmem_we,
  output logic               stop,
  output logic [7:0]         pc,
  output logic [7:0]         acc,
  output logic               zf,
  output logic               cf,
  output logic               illegal
);

  localparam logic [3:0] PH_FETCH  = 4'b0001;
  localparam logic [3:0] PH_DECODE = 4'b0010;
  localparam logic [3:0] PH_EXEC   = 4'b0100;
  localparam logic [3:0] PH_WB     = 4'b1000;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_JC   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [7:0]  r_pc;
  logic [15:0] r_ir;
  logic [7:0]  r_acc;
  logic        r_zf;
  logic        r_cf;
  logic [7:0]  r_result;  // ALU output captured at execute
  logic        r_carry;   // pending carry, committed only by ADDI/SUBI

  logic [3:0]  w_opc;
  logic [7:0]  w_imm;
  logic [8:0]  w_sum9;
  logic [8:0]  w_diff9;
  logic [7:0]  w_alu_res;
  logic        w_alu_carry;
  logic        w_wb;
  logic        w_halt_req;
  logic        w_unused;

  assign w_opc = r_ir[15:12];
  assign w_imm = r_ir[7:0];
  // IR[11:8] carries no meaning in this instruction set.
  assign w_unused = ^r_ir[11:8];

  // Only an exact one-hot writeback value counts; any other vector is idle.
  assign w_wb = (phase == PH_WB);

  // 9-bit arithmetic: bit 8 is carry for ADDI and borrow for SUBI.
  assign w_sum9  = {1'b0, r_acc} + {1'b0, w_imm};
  assign w_diff9 = {1'b0, r_acc} - {1'b0, w_imm};

  always_comb begin
    w_alu_res   = r_acc;
    w_alu_carry = 1'b0;
    case (w_opc)
      OP_LDI:  w_alu_res = w_imm;
      OP_ADDI: begin
        w_alu_res   = w_sum9[7:0];
        w_alu_carry = w_sum9[8];
      end
      OP_SUBI: begin
        w_alu_res   = w_diff9[7:0];
        w_alu_carry = w_diff9[8];
      end
      OP_LD:   w_alu_res = dmem_rdata;
      default: ;
    endcase
  end

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  logic r_illegal;
  logic w_illegal_opc;
  assign w_illegal_opc = (w_opc >= 4'h9) && (w_opc <= 4'hE);
  assign w_halt_req    = (w_opc == OP_HALT) || w_illegal_opc;
  assign illegal       = r_illegal;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_illegal <= 1'b0;
    end else if (w_wb && w_illegal_opc) begin
      r_illegal <= 1'b1;
    end
  end
`else
  assign w_halt_req = (w_opc == OP_HALT);
  assign illegal    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_pc     <= PC_RESET;
      r_ir     <= 16'h0000;
      r_acc    <= 8'h00;
      r_zf     <= 1'b0;
      r_cf     <= 1'b0;
      r_result <= 8'h00;
      r_carry  <= 1'b0;
    end else begin
      case (phase)
        PH_FETCH:  r_ir <= imem_data;
        PH_DECODE: r_pc <= r_pc + 8'd1;
        PH_EXEC: begin
          r_result <= w_alu_res;
          r_carry  <= w_alu_carry;
        end
        PH_WB: begin
          // Branches test r_zf/r_cf before this edge commits anything new.
          case (w_opc)
            OP_LDI, OP_LD: begin
              r_acc <= r_result;
              r_zf  <= (r_result == 8'h00);
            end
            OP_ADDI, OP_SUBI: begin
              r_acc <= r_result;
              r_zf  <= (r_result == 8'h00);
              r_cf  <= r_carry;
            end
            OP_JMP: r_pc <= w_imm;
            OP_JZ:  if (r_zf) r_pc <= w_imm;
            OP_JC:  if (r_cf) r_pc <= w_imm;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = r_pc;
  assign dmem_addr  = r_ir[DMEM_AW-1:0];
  assign dmem_wdata = r_acc;
  assign dmem_we    = w_wb && (w_opc == OP_ST);
  assign stop       = w_wb && w_halt_req;
  assign pc         = r_pc;
  assign acc        = r_acc;
  assign zf         = r_zf;
  assign cf         = r_cf;

endmodule

// File: tb/tb_cpu_seq.sv
module tb_cpu_seq;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [3:0]  phase = 4'b0000;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_rdata;
  logic [7:0]  dmem_wdata;
  logic        dmem_we;
  logic        stop;
  logic [7:0]  pc;
  logic [7:0]  acc;
  logic        zf;
  logic        cf;
  logic        illegal;

  int total = 0;
  int bad = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  cpu_seq #(.PC_RESET(8'h00), .DMEM_AW(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .phase(phase),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .stop(stop),
    .pc(pc), .acc(acc), .zf(zf), .cf(cf), .illegal(illegal)
  );

  // ---------------- memories seen by the DUT ----------------
  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  assign imem_data  = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  always @(posedge CLK) if (dmem_we) dmem[dmem_addr] <= dmem_wdata;

  // ---------------- reference model (instruction level) ----------------
  logic [7:0] m_pc, m_acc;
  logic       m_zf, m_cf, m_ill;
  logic [7:0] m_mem [256];
  logic [7:0] e_fetch, e_waddr, e_wdata;
  logic       e_stop, e_we;

  task automatic model_reset();
    m_pc = 8'h00; m_acc = 8'h00; m_zf = 1'b0; m_cf = 1'b0; m_ill = 1'b0;
  endtask

  // Executes the instruction at m_pc as one whole step.
  task automatic model_step();
    logic [15:0] ins;
    logic [3:0]  opc;
    logic [7:0]  imm;
    int          r;
    ins = imem[m_pc];
    opc = ins[15:12];
    imm = ins[7:0];
    e_fetch = m_pc;
    e_we    = (opc == 4'h5);
    e_waddr = imm;
    e_wdata = m_acc;
    e_stop  = (opc == 4'hF);
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    if (opc >= 4'h9 && opc <= 4'hE) begin
      e_stop = 1'b1;
      m_ill  = 1'b1;
    end
`endif
    m_pc = m_pc + 8'd1;
    case (opc)
      4'h1: begin m_acc = imm; m_zf = (m_acc == 0); end
      4'h2: begin
        r = int'(m_acc) + int'(imm);
        m_cf = (r > 255); m_acc = 8'(r); m_zf = (m_acc == 0);
      end
      4'h3: begin
        r = int'(m_acc) - int'(imm);
        m_cf = (r < 0); m_acc = 8'(r); m_zf = (m_acc == 0);
      end
      4'h4: begin m_acc = m_mem[imm]; m_zf = (m_acc == 0); end
      4'h5: m_mem[imm] = m_acc;
      4'h6: m_pc = imm;
      4'h7: if (m_zf) m_pc = imm;
      4'h8: if (m_cf) m_pc = imm;
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  logic [7:0] o_fetch_addr, o_waddr, o_wdata;
  logic       o_stop, o_we;
  int         o_stray;

  // Runs one instruction back to back: entered and left #1 after a rising edge.
  task automatic drive_instr();
    o_stray = 0;
    for (int p = 0; p < 4; p++) begin
      phase = 4'(1 << p);
      @(negedge CLK);
      if (p == 0) o_fetch_addr = imem_addr;
      if (p == 3) begin
        o_stop = stop; o_we = dmem_we; o_waddr = dmem_addr; o_wdata = dmem_wdata;
      end else if (stop !== 1'b0 || dmem_we !== 1'b0) begin
        o_stray++;
      end
      @(posedge CLK);
      #1;
    end
    phase = 4'b0000;
  endtask

  task automatic do_reset();
    phase = 4'b0000;
    RSTN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
    model_reset();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h0000; dmem[i] = 8'h00; m_mem[i] = 8'h00;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    phase = 4'b0100;
    RSTN = 1'b0;
    #1;
    total++;
    if ({pc, acc, zf, cf, illegal, stop, dmem_we} !== 21'h0) begin
      bad++; $display("FAIL reset_outputs: got pc=%0h acc=%0h zf=%0b cf=%0b ill=%0b stop=%0b we=%0b want all zero",
                      pc, acc, zf, cf, illegal, stop, dmem_we);
    end
    total++;
    if (imem_addr !== 8'h00) begin bad++; $display("FAIL reset_imem_addr: got %0h want 00", imem_addr); end
    do_reset();
  endtask

  task automatic test_add_halt();
    clear_mem();
    imem[0] = 16'h1005; imem[1] = 16'h20FE; imem[2] = 16'hF000;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      model_step();
      drive_instr();
      total++;
      if (o_stop !== (i == 2)) begin bad++; $display("FAIL add_halt_stop%0d: got %0b want %0b", i, o_stop, (i == 2)); end
    end
    total++;
    if ({acc, cf, zf, pc} !== {8'h03, 1'b1, 1'b0, 8'h03}) begin
      bad++; $display("FAIL add_halt_state: got acc=%0h cf=%0b zf=%0b pc=%0h want acc=03 cf=1 zf=0 pc=03", acc, cf, zf, pc);
    end
  endtask

  task automatic test_jz();
    clear_mem();
    imem[0] = 16'h1003; imem[1] = 16'h3003; imem[2] = 16'h7010;
    do_reset();
    repeat (3) begin model_step(); drive_instr(); end
    total++;
    if ({zf, cf, pc} !== {1'b1, 1'b0, 8'h10}) begin
      bad++; $display("FAIL jz_taken: got zf=%0b cf=%0b pc=%0h want zf=1 cf=0 pc=10", zf, cf, pc);
    end
    model_step(); drive_instr();
    total++;
    if (o_fetch_addr !== 8'h10) begin bad++; $display("FAIL jz_target_fetch: got %0h want 10", o_fetch_addr); end
  endtask

  task automatic test_jc();
    clear_mem();
    imem[0] = 16'h1001; imem[1] = 16'h3002; imem[2] = 16'h8020;
    do_reset();
    repeat (3) begin model_step(); drive_instr(); end
    total++;
    if ({acc, cf, pc} !== {8'hFF, 1'b1, 8'h20}) begin
      bad++; $display("FAIL jc_borrow: got acc=%0h cf=%0b pc=%0h want acc=ff cf=1 pc=20", acc, cf, pc);
    end
    imem[0] = 16'h1003;
    do_reset();
    repeat (3) begin model_step(); drive_instr(); end
    total++;
    if ({acc, cf, pc} !== {8'h01, 1'b0, 8'h03}) begin
      bad++; $display("FAIL jc_no_borrow: got acc=%0h cf=%0b pc=%0h want acc=01 cf=0 pc=03", acc, cf, pc);
    end
  endtask

  task automatic test_store_load();
    int we_cnt;
    clear_mem();
    imem[0] = 16'h10A5; imem[1] = 16'h5040; imem[2] = 16'h1000; imem[3] = 16'h4040;
    do_reset();
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      model_step();
      drive_instr();
      we_cnt += o_stray + int'(o_we);
      if (i == 1) begin
        total++;
        if ({o_we, o_waddr, o_wdata} !== {1'b1, 8'h40, 8'hA5}) begin
          bad++; $display("FAIL st_strobe: got we=%0b addr=%0h data=%0h want we=1 addr=40 data=a5", o_we, o_waddr, o_wdata);
        end
      end
    end
    total++;
    if (we_cnt !== 1) begin bad++; $display("FAIL st_we_cycles: got %0d want 1", we_cnt); end
    total++;
    if ({acc, zf} !== {8'hA5, 1'b0}) begin bad++; $display("FAIL ld_result: got acc=%0h zf=%0b want acc=a5 zf=0", acc, zf); end
  endtask

  task automatic test_wrap();
    clear_mem();
    imem[0] = 16'h60FF; imem[8'hFF] = 16'h0000;
    do_reset();
    repeat (2) begin model_step(); drive_instr(); end
    total++;
    if (pc !== 8'h00) begin bad++; $display("FAIL pc_wrap: got %0h want 00", pc); end
  endtask

  task automatic test_reset_mid();
    clear_mem();
    imem[0] = 16'h1077; imem[1] = 16'h2099;
    do_reset();
    model_step(); drive_instr();
    phase = 4'b0001; @(posedge CLK); #1;
    phase = 4'b0010; @(posedge CLK); #1;
    phase = 4'b0100;
    @(negedge CLK);
    RSTN = 1'b0;
    #1;
    total++;
    if ({pc, acc, zf, cf, illegal, stop, dmem_we, imem_addr} !== 29'h0) begin
      bad++; $display("FAIL reset_mid_exec: got pc=%0h acc=%0h zf=%0b cf=%0b ill=%0b stop=%0b we=%0b want zeros",
                      pc, acc, zf, cf, illegal, stop, dmem_we);
    end
    do_reset();
    model_step(); drive_instr();
    total++;
    if ({acc, pc} !== {8'h77, 8'h01}) begin bad++; $display("FAIL reset_mid_restart: got acc=%0h pc=%0h want 77/01", acc, pc); end
  endtask

  task automatic test_illegal();
    logic exp_ill;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    clear_mem();
    imem[0] = 16'h1012; imem[1] = 16'h9034; imem[2] = 16'h0000;
    do_reset();
    model_step(); drive_instr();
    model_step(); drive_instr();
    total++;
    if ({o_stop, illegal} !== {exp_ill, exp_ill}) begin
      bad++; $display("FAIL illegal_op: got stop=%0b ill=%0b want %0b/%0b", o_stop, illegal, exp_ill, exp_ill);
    end
    total++;
    if ({acc, pc, zf, cf} !== {8'h12, 8'h02, 1'b0, 1'b0}) begin
      bad++; $display("FAIL illegal_state: got acc=%0h pc=%0h zf=%0b cf=%0b want 12/02/0/0", acc, pc, zf, cf);
    end
    model_step(); drive_instr();
    total++;
    if (illegal !== exp_ill) begin bad++; $display("FAIL illegal_sticky: got %0b want %0b", illegal, exp_ill); end
  endtask

  task automatic test_idle();
    logic [3:0] idle_pat [7] = '{4'b0000, 4'b0011, 4'b0101, 4'b1111, 4'b1100, 4'b1010, 4'b0110};
    int stray;
    clear_mem();
    imem[0] = 16'h1033; imem[1] = 16'h2001;
    do_reset();
    model_step(); drive_instr();
    stray = 0;
    foreach (idle_pat[k]) begin
      phase = idle_pat[k];
      @(negedge CLK);
      if (stop !== 1'b0 || dmem_we !== 1'b0) stray++;
      @(posedge CLK); #1;
    end
    phase = 4'b0000;
    total++;
    if (stray !== 0) begin bad++; $display("FAIL idle_strobes: got %0d want 0", stray); end
    total++;
    if ({pc, acc, zf, cf} !== {8'h01, 8'h33, 1'b0, 1'b0}) begin
      bad++; $display("FAIL idle_hold: got pc=%0h acc=%0h zf=%0b cf=%0b want 01/33/0/0", pc, acc, zf, cf);
    end
    model_step(); drive_instr();
    total++;
    if (acc !== 8'h34) begin bad++; $display("FAIL idle_then_run: got acc=%0h want 34", acc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'($urandom);
      dmem[i] = 8'($urandom);
      m_mem[i] = dmem[i];
    end
    do_reset();
    for (int n = 0; n < 300; n++) begin
      model_step();
      drive_instr();
      total++;
      if (o_fetch_addr !== e_fetch) begin bad++; $display("FAIL rnd_fetch n=%0d: got %0h want %0h", n, o_fetch_addr, e_fetch); end
      total++;
      if ({o_stop, o_we, o_stray} !== {e_stop, e_we, 32'd0}) begin
        bad++; $display("FAIL rnd_strobes n=%0d: got stop=%0b we=%0b stray=%0d want stop=%0b we=%0b stray=0",
                        n, o_stop, o_we, o_stray, e_stop, e_we);
      end
      if (e_we) begin
        total++;
        if ({o_waddr, o_wdata} !== {e_waddr, e_wdata}) begin
          bad++; $display("FAIL rnd_store n=%0d: got addr=%0h data=%0h want addr=%0h data=%0h", n, o_waddr, o_wdata, e_waddr, e_wdata);
        end
      end
      total++;
      if ({pc, acc, zf, cf, illegal} !== {m_pc, m_acc, m_zf, m_cf, m_ill}) begin
        bad++; $display("FAIL rnd_state n=%0d: got pc=%0h acc=%0h zf=%0b cf=%0b ill=%0b want pc=%0h acc=%0h zf=%0b cf=%0b ill=%0b",
                        n, pc, acc, zf, cf, illegal, m_pc, m_acc, m_zf, m_cf, m_ill);
      end
    end
  endtask

  initial begin
    clear_mem();
    model_reset();
    test_reset();
    test_add_halt();
    test_jz();
    test_jc();
    test_store_load();
    test_wrap();
    test_reset_mid();
    test_illegal();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
